counter_ctrl: RTL and testbench
===============================

Name: counter_ctrl

Overview:
Control stage that sits directly upstream of the 4-bit up/down counter and drives its Load, Count_en, Up and Count_in inputs. It conditions three raw push-buttons (load, run/stop, direction) and produces a timed count-enable tick from a prescaler. It can also halt counting at the 0/15 limit, using the counter's output fed back. All outputs are registered on rising Clk, so they are stable before the counter samples them on the falling edge.

Parameters:
TICK_DIV, 12_500_000, Clk cycles between Count_en pulses while running; must be >= 2.
DB_CYCLES, 500_000, Clk cycles a synchronized button level must stay stable before it is accepted; must be >= 1.

Ports:
Clk  input  1  system clock, rising-edge active
Reset  input  1  synchronous, active-high reset
Btn_load  input  1  raw load button, active-high, asynchronous
Btn_run  input  1  raw run/stop button, active-high, asynchronous
Btn_dir  input  1  raw direction-toggle button, active-high, asynchronous
Sw_data  input  4  value to load into the counter
Wrap_en  input  1  1 = free wrap-around; 0 = halt at limit
Count_fb  input  4  counter's current Count_out
Load  output  1  one-cycle load strobe to the counter
Count_en  output  1  one-cycle count strobe to the counter
Up  output  1  direction to the counter, 1 = up
Count_in  output  4  load value, captured from Sw_data
Running  output  1  high while in RUN
At_limit  output  1  high while in HALT

Behaviour:
- Reset (sampled on rising Clk): Load=0, Count_en=0, Up=1, Count_in=0, Running=0, At_limit=0.
  - Reset also clears the state (to IDLE), the prescaler, the debounce counters and the synchronizer flops.
  - Reset overrides everything, including a RUN in progress and an active strobe.
- Button conditioning, per button:
  - 2-flop synchronizer, then debounce.
  - The accepted level changes only after the synchronized level has differed from it for DB_CYCLES consecutive cycles.
  - A rising edge of the accepted level gives a one-cycle press pulse.
  - Holding a button gives exactly one pulse. A glitch shorter than DB_CYCLES gives none.
  - Press-to-pulse latency is DB_CYCLES+3 cycles.
- Direction: a dir press toggles Up the next cycle, in any state. It is processed independently of load and run presses.
- FSM states: IDLE, LOAD, RUN, HALT.
  - Any state, load press -> LOAD. Count_in<=Sw_data, Load=1 for exactly one cycle, then IDLE.
  - A load press has priority over a run press in the same cycle; the run press is dropped.
  - IDLE, run press -> RUN. Prescaler cleared to 0.
  - RUN, run press -> IDLE. No tick in that cycle.
  - HALT, run press -> RUN. Prescaler cleared to 0.
  - RUN: prescaler counts 0..TICK_DIV-1. At TICK_DIV-1 it wraps to 0 and a tick occurs. The first tick comes TICK_DIV cycles after entering RUN.
  - On a tick, if Wrap_en=1, or the counter is not at the limit, Count_en=1 for one cycle.
  - The limit is Count_fb==15 with Up=1, or Count_fb==0 with Up=0.
  - On a tick with Wrap_en=0 and at the limit: Count_en is suppressed and the state goes to HALT.
  - HALT entered at a limit re-halts on the next tick if the direction is unchanged.
- Invariants:
  - Load and Count_en are never both 1.
  - Count_en=0 outside RUN.
  - Running=1 exactly in RUN; At_limit=1 exactly in HALT.
- Feedback timing: the counter updates on the falling edge after Count_en. Count_fb is therefore valid by the next rising edge, and TICK_DIV>=2 guarantees it is current at every tick.
- Prescaler width is $clog2(TICK_DIV); debounce counter width is $clog2(DB_CYCLES+1).

Decomposition:
- Package counter_ctrl_pkg: FSM state type with encodings IDLE=2'd0, LOAD=2'd1, RUN=2'd2, HALT=2'd3; constants UP_LIMIT=4'd15 and DOWN_LIMIT=4'd0.
- Sub-module btn_conditioner (synchronizer + debounce + rising-edge pulse, parameter DB_CYCLES), instantiated three times.
- FSM and prescaler stay in counter_ctrl.

Test Plan (TICK_DIV=4, DB_CYCLES=3, behavioural model of the negedge counter attached):
- Reset held 2 cycles mid-RUN -> next cycle Load=0, Count_en=0, Up=1, Count_in=0, Running=0, At_limit=0, state IDLE.
- Sw_data=4'hA, Btn_load held 20 cycles -> exactly one Load pulse with Count_in=4'hA, 6 cycles after the press; counter reads 4'hA; state IDLE.
- Counter at 0, run press -> Running=1; Count_en pulses every 4 cycles, first 4 cycles after RUN entry; counter reads 1,2,3; second run press -> IDLE, pulses stop.
- Wrap_en=0, counter loaded to 14, run -> one tick gives 15; next tick suppressed, At_limit=1, Running=0; dir press then run press -> Up=0, counter reads 14, 13.
- Wrap_en=1, counter at 15, Up=1, run -> counter reads 0 then 1; no HALT.
- 2-cycle glitch on Btn_run -> no state change. Btn_load and Btn_run pressed in the same cycle -> one Load pulse, state IDLE, Running stays 0.

Source files
------------

// File: rtl/counter_ctrl_pkg.sv
// Shared types and constants for the counter control stage: FSM state
// encoding and the 0/15 count limits.
package counter_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        HALT = 2'd3
    } state_e;

    localparam logic [3:0] UP_LIMIT   = 4'd15;
    localparam logic [3:0] DOWN_LIMIT = 4'd0;

    // True when one more step in the given direction would wrap the counter.
    function automatic logic is_at_limit(input logic [3:0] value, input logic up);
        return up ? (value == UP_LIMIT) : (value == DOWN_LIMIT);
    endfunction

endpackage

// File: rtl/btn_conditioner.sv
// Raw push-button conditioning: 2-flop synchronizer, level debounce and a
// one-cycle pulse on each accepted rising edge.
module btn_conditioner #(
    parameter int unsigned DB_CYCLES = 500_000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_i,
    output logic pulse_o
);

    localparam int unsigned CW = $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          level_q;
    logic          pulse_q;
    logic [CW-1:0] cnt_q;

    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            pulse_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            pulse_q <= 1'b0;
            if (sync2_q != level_q) begin
                // Accept on the DB_CYCLES-th consecutive differing sample.
                if (cnt_q == CNT_LAST) begin
                    level_q <= sync2_q;
                    pulse_q <= sync2_q;
                    cnt_q   <= '0;
                end else begin
                    cnt_q <= cnt_q + CW'(1);
                end
            end else begin
                cnt_q <= '0;
            end
        end
    end

    assign pulse_o = pulse_q;

endmodule

// File: rtl/counter_ctrl.sv
// Control stage for the 4-bit up/down counter: conditioned buttons, a
// load/run/halt FSM and a prescaled count-enable tick, all outputs registered.
module counter_ctrl
    import counter_ctrl_pkg::*;
#(
    parameter int unsigned TICK_DIV  = 12_500_000,
    parameter int unsigned DB_CYCLES = 500_000
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Btn_load,
    input  logic       Btn_run,
    input  logic       Btn_dir,
    input  logic [3:0] Sw_data,
    input  logic       Wrap_en,
    input  logic [3:0] Count_fb,
    output logic       Load,
    output logic       Count_en,
    output logic       Up,
    output logic [3:0] Count_in,
    output logic       Running,
    output logic       At_limit
);

    localparam int unsigned PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

    logic load_p;
    logic run_p;
    logic dir_p;

    btn_conditioner #(.DB_CYCLES(DB_CYCLES)) u_btn_load (
        .clk_i   (Clk),
        .rst_i   (Reset),
        .btn_i   (Btn_load),
        .pulse_o (load_p)
    );

    btn_conditioner #(.DB_CYCLES(DB_CYCLES)) u_btn_run (
        .clk_i   (Clk),
        .rst_i   (Reset),
        .btn_i   (Btn_run),
        .pulse_o (run_p)
    );

    btn_conditioner #(.DB_CYCLES(DB_CYCLES)) u_btn_dir (
        .clk_i   (Clk),
        .rst_i   (Reset),
        .btn_i   (Btn_dir),
        .pulse_o (dir_p)
    );

    state_e        state_q;
    logic [PW-1:0] pre_q;
    logic          load_q;
    logic          cen_q;
    logic          up_q;
    logic [3:0]    cin_q;
    logic          running_q;
    logic          at_limit_q;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= IDLE;
            pre_q      <= '0;
            load_q     <= 1'b0;
            cen_q      <= 1'b0;
            up_q       <= 1'b1;
            cin_q      <= 4'd0;
            running_q  <= 1'b0;
            at_limit_q <= 1'b0;
        end else begin
            load_q <= 1'b0;
            cen_q  <= 1'b0;
            if (dir_p) begin
                up_q <= ~up_q;
            end
            // A load press wins over everything else, including a same-cycle run press.
            if (load_p) begin
                state_q    <= LOAD;
                cin_q      <= Sw_data;
                load_q     <= 1'b1;
                running_q  <= 1'b0;
                at_limit_q <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (run_p) begin
                            state_q   <= RUN;
                            pre_q     <= '0;
                            running_q <= 1'b1;
                        end
                    end
                    LOAD: begin
                        state_q <= IDLE;
                    end
                    RUN: begin
                        if (run_p) begin
                            state_q   <= IDLE;
                            running_q <= 1'b0;
                        end else if (pre_q == PRE_LAST) begin
                            pre_q <= '0;
                            if (Wrap_en || !is_at_limit(Count_fb, up_q)) begin
                                cen_q <= 1'b1;
                            end else begin
                                state_q    <= HALT;
                                running_q  <= 1'b0;
                                at_limit_q <= 1'b1;
                            end
                        end else begin
                            pre_q <= pre_q + PW'(1);
                        end
                    end
                    HALT: begin
                        if (run_p) begin
                            state_q    <= RUN;
                            pre_q      <= '0;
                            running_q  <= 1'b1;
                            at_limit_q <= 1'b0;
                        end
                    end
                    default: begin
                        state_q    <= IDLE;
                        running_q  <= 1'b0;
                        at_limit_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign Load     = load_q;
    assign Count_en = cen_q;
    assign Up       = up_q;
    assign Count_in = cin_q;
    assign Running  = running_q;
    assign At_limit = at_limit_q;

endmodule

// File: tb/tb_counter_ctrl.sv
// Bench for counter_ctrl: directed scenarios plus random button traffic, with a
// negedge 4-bit counter in the loop and a cycle-level reference model.
module tb_counter_ctrl;

    localparam int TICK_DIV  = 4;
    localparam int DB_CYCLES = 3;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       Btn_load;
    logic       Btn_run;
    logic       Btn_dir;
    logic [3:0] Sw_data;
    logic       Wrap_en;
    logic [3:0] Count_fb;
    logic       Load;
    logic       Count_en;
    logic       Up;
    logic [3:0] Count_in;
    logic       Running;
    logic       At_limit;

    counter_ctrl #(.TICK_DIV(TICK_DIV), .DB_CYCLES(DB_CYCLES)) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .Btn_load (Btn_load),
        .Btn_run  (Btn_run),
        .Btn_dir  (Btn_dir),
        .Sw_data  (Sw_data),
        .Wrap_en  (Wrap_en),
        .Count_fb (Count_fb),
        .Load     (Load),
        .Count_en (Count_en),
        .Up       (Up),
        .Count_in (Count_in),
        .Running  (Running),
        .At_limit (At_limit)
    );

    always #5 Clk = ~Clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: mode, expected registered outputs, and per-button history.
    typedef enum {M_IDLE, M_LOAD, M_RUN, M_HALT} mmode_t;
    mmode_t     m_mode;
    int         run_age;
    bit         e_load, e_cen, e_up;
    bit [3:0]   e_cin;
    bit         seen1[3], seen2[3], acc[3], pulse[3];
    int         streak[3];

    task automatic model_step();
        bit raw[3];
        bit old_up;
        bit delayed;
        bit limit;
        raw[0] = Btn_load;
        raw[1] = Btn_run;
        raw[2] = Btn_dir;
        if (Reset) begin
            m_mode = M_IDLE; run_age = 0;
            e_load = 0; e_cen = 0; e_up = 1; e_cin = 0;
            for (int i = 0; i < 3; i++) begin
                seen1[i] = 0; seen2[i] = 0; acc[i] = 0; pulse[i] = 0; streak[i] = 0;
            end
            return;
        end
        e_load = 0;
        e_cen  = 0;
        old_up = e_up;
        if (pulse[2]) e_up = !e_up;
        if (pulse[0]) begin
            m_mode = M_LOAD; e_cin = Sw_data; e_load = 1;
        end else begin
            case (m_mode)
                M_IDLE, M_HALT: if (pulse[1]) begin m_mode = M_RUN; run_age = 0; end
                M_LOAD: m_mode = M_IDLE;
                M_RUN: begin
                    if (pulse[1]) m_mode = M_IDLE;
                    else begin
                        run_age++;
                        if (run_age % TICK_DIV == 0) begin
                            limit = (old_up && Count_fb == 4'd15) || (!old_up && Count_fb == 4'd0);
                            if (Wrap_en || !limit) e_cen = 1;
                            else m_mode = M_HALT;
                        end
                    end
                end
            endcase
        end
        // Debounce sees the raw level from two edges ago.
        for (int i = 0; i < 3; i++) begin
            delayed  = seen2[i];
            seen2[i] = seen1[i];
            seen1[i] = raw[i];
            pulse[i] = 0;
            if (delayed != acc[i]) begin
                streak[i]++;
                if (streak[i] == DB_CYCLES) begin
                    acc[i] = delayed; streak[i] = 0; pulse[i] = delayed;
                end
            end else begin
                streak[i] = 0;
            end
        end
    endtask

    function automatic logic [8:0] outs();
        return {Load, Count_en, Up, Count_in, Running, At_limit};
    endfunction

    // One clock: model at the rising edge, compare and advance the counter at the falling edge.
    task automatic cycle();
        @(posedge Clk);
        model_step();
        @(negedge Clk);
        check("outputs", {23'd0, outs()},
              {23'd0, e_load, e_cen, e_up, e_cin, m_mode == M_RUN, m_mode == M_HALT});
        if (Load) Count_fb = Count_in;
        else if (Count_en) Count_fb = Up ? Count_fb + 4'd1 : Count_fb - 4'd1;
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    function automatic bit cond(input int kind);
        case (kind)
            0:       return Count_en === 1'b1;
            1:       return At_limit === 1'b1;
            2:       return Running === 1'b0;
            3:       return Up === 1'b0;
            default: return Running === 1'b1;
        endcase
    endfunction

    task automatic wait_for(input string name, input int kind, input int limit, output int steps);
        bit hit;
        hit = 0;
        steps = 0;
        while (!hit && steps < limit) begin
            cycle();
            steps++;
            hit = cond(kind);
        end
        check({name, "_seen"}, {31'd0, hit}, 32'd1);
    endtask

    task automatic press(input int b, input int hold, input int settle);
        case (b)
            0: Btn_load = 1;
            1: Btn_run = 1;
            default: Btn_dir = 1;
        endcase
        cycles(hold);
        Btn_load = 0; Btn_run = 0; Btn_dir = 0;
        cycles(settle);
    endtask

    initial begin
        int steps;
        int n_load, first_load, n_cen;
        logic [3:0] snap;
        int hold_left[3];

        Reset = 1; Btn_load = 0; Btn_run = 0; Btn_dir = 0;
        Sw_data = 4'h0; Wrap_en = 0; Count_fb = 4'h0;
        cycles(2);
        Reset = 0;
        cycles(2);
        check("reset_outs", {23'd0, outs()}, 32'h040);

        // Held load button: a single Load strobe DB_CYCLES+3 cycles after the press.
        Sw_data = 4'hA;
        Btn_load = 1;
        n_load = 0; first_load = 0;
        for (int i = 1; i <= 20; i++) begin
            cycle();
            if (Load) begin n_load++; if (first_load == 0) first_load = i; end
        end
        Btn_load = 0;
        for (int i = 0; i < 8; i++) begin cycle(); if (Load) n_load++; end
        check("load_pulses", n_load, 1);
        check("load_latency", first_load, 6);
        check("load_value", {28'd0, Count_fb}, 32'hA);
        check("load_idle", {30'd0, Running, At_limit}, 0);

        // Run from 0: ticks every TICK_DIV cycles, then stop.
        Sw_data = 4'h0;
        press(0, 8, 4);
        check("load_zero", {28'd0, Count_fb}, 0);
        Btn_run = 1;
        wait_for("run_entry", 4, 12, steps);
        check("run_entry_lat", steps, 6);
        wait_for("tick1", 0, 8, steps);
        Btn_run = 0;
        check("tick1_lat", steps, TICK_DIV);
        check("tick1_val", {28'd0, Count_fb}, 1);
        wait_for("tick2", 0, 8, steps);
        check("tick2_gap", steps, TICK_DIV);
        check("tick2_val", {28'd0, Count_fb}, 2);
        wait_for("tick3", 0, 8, steps);
        check("tick3_val", {28'd0, Count_fb}, 3);
        Btn_run = 1;
        wait_for("stop", 2, 12, steps);
        Btn_run = 0;
        snap = Count_fb;
        n_cen = 0;
        for (int i = 0; i < 12; i++) begin cycle(); if (Count_en) n_cen++; end
        check("stopped_ticks", n_cen, 0);
        check("stopped_val", {28'd0, Count_fb}, {28'd0, snap});

        // Halt at the upper limit, reverse, count down.
        Wrap_en = 0;
        Sw_data = 4'd14;
        press(0, 8, 4);
        check("load_14", {28'd0, Count_fb}, 14);
        Btn_run = 1;
        wait_for("halt_tick", 0, 20, steps);
        Btn_run = 0;
        check("halt_to15", {28'd0, Count_fb}, 15);
        wait_for("halt", 1, 8, steps);
        check("halt_steps", steps, TICK_DIV);
        check("halt_not_run", {31'd0, Running}, 0);
        check("halt_val", {28'd0, Count_fb}, 15);
        Btn_dir = 1;
        wait_for("dir_down", 3, 12, steps);
        Btn_dir = 0;
        cycles(6);
        Btn_run = 1;
        wait_for("down1", 0, 20, steps);
        Btn_run = 0;
        check("down_14", {28'd0, Count_fb}, 14);
        wait_for("down2", 0, 8, steps);
        check("down_13", {28'd0, Count_fb}, 13);
        Btn_run = 1;
        wait_for("stop2", 2, 12, steps);
        Btn_run = 0;
        cycles(6);

        // Wrap-around through 15 -> 0 -> 1.
        press(2, 8, 4);
        check("dir_up", {31'd0, Up}, 1);
        Wrap_en = 1;
        Sw_data = 4'd15;
        press(0, 8, 4);
        Btn_run = 1;
        wait_for("wrap1", 0, 20, steps);
        Btn_run = 0;
        check("wrap_to0", {28'd0, Count_fb}, 0);
        wait_for("wrap2", 0, 8, steps);
        check("wrap_to1", {28'd0, Count_fb}, 1);
        check("wrap_no_halt", {30'd0, Running, At_limit}, 2'b10);

        // Reset in the middle of a run, with Up toggled to 0 beforehand.
        Btn_run = 1;
        wait_for("stop3", 2, 12, steps);
        Btn_run = 0;
        cycles(6);
        Btn_run = 1; Btn_dir = 1;
        wait_for("rerun", 4, 12, steps);
        Btn_run = 0; Btn_dir = 0;
        wait_for("rerun_tick", 0, 8, steps);
        Reset = 1;
        cycles(2);
        Reset = 0;
        check("mid_run_reset", {23'd0, outs()}, 32'h040);
        cycles(4);
        check("post_reset_idle", {31'd0, Running}, 0);

        // Short glitch on run: ignored.
        Btn_run = 1;
        cycles(2);
        Btn_run = 0;
        cycles(15);
        check("glitch_idle", {31'd0, Running}, 0);

        // Load and run together: load wins, run dropped.
        Sw_data = 4'h5;
        Btn_load = 1; Btn_run = 1;
        n_load = 0;
        for (int i = 0; i < 14; i++) begin cycle(); if (Load) n_load++; end
        Btn_load = 0; Btn_run = 0;
        for (int i = 0; i < 10; i++) begin cycle(); if (Load) n_load++; end
        check("both_load_pulses", n_load, 1);
        check("both_not_running", {31'd0, Running}, 0);
        check("both_value", {28'd0, Count_fb}, 5);

        // Random button traffic against the model.
        for (int b = 0; b < 3; b++) hold_left[b] = 0;
        for (int c = 0; c < 4000; c++) begin
            for (int b = 0; b < 3; b++) begin
                if (hold_left[b] == 0) begin
                    bit lvl;
                    lvl = (b == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 1) == 1);
                    hold_left[b] = $urandom_range(1, 14);
                    case (b)
                        0: Btn_load = lvl;
                        1: Btn_run = lvl;
                        default: Btn_dir = lvl;
                    endcase
                end
                hold_left[b]--;
            end
            if ($urandom_range(0, 31) == 0) Sw_data = 4'($urandom);
            if ($urandom_range(0, 99) == 0) Wrap_en = ~Wrap_en;
            Reset = ($urandom_range(0, 799) == 0);
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
